// File: rtl/fp_class_pipe.sv
// fp_class_pipe: registered floating-point classifier with a valid/ready handshake.
// It emits a RISC-V fclass-style one-hot class, with zero split out from subnormal
// and sNaN split from qNaN. It also keeps a saturating event counter for each class.
module fp_class_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [EXP_W+MAN_W:0]   in_num_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [9:0]             out_class_o,
    output logic [EXP_W+MAN_W:0]   out_num_o,
    input  logic                   cnt_clr_i,
    input  logic [3:0]             cnt_sel_i,
    output logic [CNT_W-1:0]       cnt_val_o
);

    localparam int W = 1 + EXP_W + MAN_W;

    logic             w_sign;
    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_man;
    logic             w_expOnes;
    logic             w_expZero;
    logic             w_manZero;
    logic [9:0]       w_class;
    logic             w_accept;
    logic [CNT_W-1:0] w_cntVal;

    logic             r_outValid;
    logic [9:0]       r_outClass;
    logic [W-1:0]     r_outNum;
    logic [CNT_W-1:0] r_cnt [10];

    assign w_sign    = in_num_i[W-1];
    assign w_exp     = in_num_i[W-2:MAN_W];
    assign w_man     = in_num_i[MAN_W-1:0];
    assign w_expOnes = &w_exp;
    assign w_expZero = ~|w_exp;
    assign w_manZero = ~|w_man;

    // The register drains while downstream takes it, so there is no bubble at full rate.
    assign in_ready_o = !r_outValid || out_ready_i;
    assign w_accept   = in_valid_i && in_ready_o;

    // Decode the incoming operand into exactly one class bit. The sign is ignored for NaNs.
    always_comb begin
        w_class = '0;
        if (w_expOnes) begin
            if (w_manZero)
                w_class[w_sign ? 0 : 7] = 1'b1;
            else if (w_man[MAN_W-1])
                w_class[9] = 1'b1;
            else
                w_class[8] = 1'b1;
        end else if (w_expZero) begin
            if (w_manZero)
                w_class[w_sign ? 3 : 4] = 1'b1;
            else
                w_class[w_sign ? 2 : 5] = 1'b1;
        end else begin
            w_class[w_sign ? 1 : 6] = 1'b1;
        end
    end

    // Output register stage. Data loads on accept; valid clears once taken with nothing new.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outValid <= 1'b0;
            r_outClass <= '0;
            r_outNum   <= '0;
        end else if (w_accept) begin
            r_outValid <= 1'b1;
            r_outClass <= w_class;
            r_outNum   <= in_num_i;
        end else if (out_ready_i) begin
            r_outValid <= 1'b0;
        end
    end

    // Per-class event counters. They saturate at all-ones, and clear wins over an increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 10; k++) r_cnt[k] <= '0;
        end else if (cnt_clr_i) begin
            for (int k = 0; k < 10; k++) r_cnt[k] <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < 10; k++) begin
                if (w_class[k] && (r_cnt[k] != {CNT_W{1'b1}}))
                    r_cnt[k] <= r_cnt[k] + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Counter readout mux. Indices beyond the ten classes read as zero.
    always_comb begin
        w_cntVal = '0;
        for (int k = 0; k < 10; k++) begin
            if (cnt_sel_i == 4'(k)) w_cntVal = r_cnt[k];
        end
    end

    assign out_valid_o = r_outValid;
    assign out_class_o = r_outClass;
    assign out_num_o   = r_outNum;
    assign cnt_val_o   = w_cntVal;

endmodule
